enc_frame_tx: RTL and testbench

ENC_FRAME_TX -- requirements
Module: enc_frame_tx

---
 rtl/enc_frame_tx.sv | 124 ++++++++++++
 tb/tb_enc_frame_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/enc_frame_tx.sv
// Frame transmitter around an external serial parity encoder.
// Flow per frame: latch the payload, pulse a clear to the encoder, shift the
// payload through it for K cycles, capture the remainder, then serialise
// payload (MSB first) followed by parity (LSB first) over a valid/ready link.
module enc_frame_tx #(
    parameter int N = 64,
    parameter int K = 40
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [K-1:0]   in_data,
    output logic           in_ready,
    output logic           enc_rst,
    output logic           enc_shift,
    output logic [K-1:0]   enc_data,
    input  logic [10:0]    enc_count,
    input  logic [N-K-1:0] enc_parity,
    output logic           tx_bit,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           tx_last,
    output logic           err
);
    localparam int P  = N - K;
    // counters must reach N-1 without wrapping
    localparam int CW = $clog2(N + 1);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] K_W = CW'(K);
    localparam logic [CW-1:0] N_W = CW'(N);

    typedef enum logic [1:0] {IDLE, CLEAR, ENCODE, EMIT} state_t;

    state_t          state, state_n;
    logic [K-1:0]    data_q;
    logic [P-1:0]    par_q;
    logic [CW-1:0]   shift_cnt;
    logic [CW-1:0]   bit_idx;
    logic            err_q;
    logic            last_shift;
    logic            last_bit;
    logic [KW-1:0]   data_idx;
    logic [PW-1:0]   par_idx;
    logic            cw_bit;

    assign last_shift = (shift_cnt == K_W - 1'b1);
    assign last_bit   = (bit_idx == N_W - 1'b1);

    // codeword bit at the current index: payload MSB-first, then parity LSB-first
    assign data_idx = KW'(K_W - 1'b1 - bit_idx);
    assign par_idx  = PW'(bit_idx - K_W);
    assign cw_bit   = (bit_idx < K_W) ? data_q[data_idx] : par_q[par_idx];

    assign enc_data = data_q;
    assign err      = err_q;
    assign tx_bit   = tx_valid & cw_bit;
    assign tx_last  = tx_valid & last_bit;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // next state and per-state strobes
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        enc_rst   = 1'b0;
        enc_shift = 1'b0;
        tx_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = CLEAR;
            end
            CLEAR: begin
                enc_rst = 1'b1;
                state_n = ENCODE;
            end
            ENCODE: begin
                enc_shift = 1'b1;
                if (last_shift) state_n = EMIT;
            end
            EMIT: begin
                tx_valid = 1'b1;
                if (tx_ready && last_bit) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // payload latch, shift counter, parity snapshot and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            par_q     <= '0;
            shift_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (in_ready && in_valid) data_q <= in_data;
            if (enc_shift) begin
                if (last_shift) begin
                    shift_cnt <= '0;
                    par_q     <= enc_parity;
                    if (enc_count != 11'(K)) err_q <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end
        end
    end

    // bit index advances only on a completed handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx <= '0;
        end else if (tx_valid && tx_ready) begin
            if (last_bit) bit_idx <= '0;
            else          bit_idx <= bit_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_enc_frame_tx.sv
// Directed bench for enc_frame_tx with a behavioural serial parity encoder.
module tb_enc_frame_tx;
    localparam int N = 64;
    localparam int K = 40;
    localparam int P = N - K;
    localparam logic [P-1:0] GEN = 24'h884110;
    localparam logic [N-1:0] CW1 = 64'h8841108000000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [K-1:0]  in_data;
    logic          in_ready;
    logic          enc_rst;
    logic          enc_shift;
    logic [K-1:0]  enc_data;
    logic [10:0]   enc_count;
    logic [P-1:0]  enc_parity;
    logic          tx_bit;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_last;
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;

    enc_frame_tx #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .enc_rst(enc_rst), .enc_shift(enc_shift),
        .enc_data(enc_data), .enc_count(enc_count), .enc_parity(enc_parity),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .err(err)
    );

    always #5 clk = ~clk;

    // encoder model: settles mid-cycle so its outputs include the current shift
    int         m_cnt;
    logic [P-1:0] m_par;
    bit         force_bad;
    always @(negedge clk or negedge rst) begin : enc_model
        logic fb;
        if (!rst) begin
            m_cnt <= 0;
            m_par <= '0;
        end else if (enc_rst) begin
            m_cnt <= 0;
            m_par <= '0;
        end else if (enc_shift && m_cnt < K) begin
            fb = enc_data[K-1-m_cnt] ^ m_par[P-1];
            m_par <= {m_par[P-2:0], 1'b0} ^ (fb ? GEN : '0);
            m_cnt <= m_cnt + 1;
        end
    end
    assign enc_parity = m_par;
    assign enc_count  = 11'(force_bad ? m_cnt - 1 : m_cnt);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // results of the last run_frame call
    logic [N-1:0] r_cw;
    int r_wait, r_lat, r_nshift, r_ecyc;
    bit r_seq_ok, r_busy_ok, r_last_ok, r_stab_ok, r_errat, r_post_rdy, r_post_vld;

    // call at a negedge; offers d, runs the frame, returns at the negedge after the last handshake
    task automatic run_frame(input logic [K-1:0] d, input bit stall, input bit keep);
        int c;
        int i;
        bit prev_stall;
        logic pb, pl;
        in_valid = 1'b1;
        in_data  = d;
        r_wait   = 0;
        while (!in_ready && r_wait < 300) begin
            @(negedge clk);
            r_wait++;
        end
        @(negedge clk);
        in_data  = ~d;
        in_valid = keep;
        c = 1; r_nshift = 0; r_seq_ok = 1; r_busy_ok = 1;
        while (!tx_valid && c < 100) begin
            if (enc_rst !== (c == 1)) r_seq_ok = 0;
            if (enc_shift && enc_rst) r_seq_ok = 0;
            if (enc_shift) r_nshift++;
            if (in_ready || enc_data !== d) r_busy_ok = 0;
            @(negedge clk);
            c++;
        end
        r_lat = c; r_errat = err; r_cw = '0;
        r_last_ok = 1; r_stab_ok = 1; i = 0; r_ecyc = 0; prev_stall = 0; pb = 0; pl = 0;
        while (tx_valid && i < N && r_ecyc < 300) begin
            if (enc_shift || enc_rst || in_ready || enc_data !== d) r_busy_ok = 0;
            if (tx_last !== (i == N-1)) r_last_ok = 0;
            if (prev_stall && (tx_bit !== pb || tx_last !== pl)) r_stab_ok = 0;
            tx_ready = stall ? (r_ecyc % 2 == 0) : 1'b1;
            r_cw[i] = tx_bit;
            pb = tx_bit; pl = tx_last; prev_stall = !tx_ready;
            if (tx_ready) i++;
            r_ecyc++;
            @(negedge clk);
        end
        if (i != N) r_last_ok = 0;
        tx_ready   = 1'b0;
        r_post_rdy = in_ready;
        r_post_vld = tx_valid;
    endtask

    initial begin
        bit idle_ok;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; tx_ready = 1'b0; force_bad = 0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_enc_shift", enc_shift, 0);
        chk("rst_enc_rst", enc_rst, 0);
        chk("rst_err", err, 0);
        chk("rst_enc_data", enc_data, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // all-zero payload
        run_frame('0, 0, 0);
        chk("z_latency", r_lat, 42);
        chk("z_nshift", r_nshift, 40);
        chk("z_seq", r_seq_ok, 1);
        chk("z_busy", r_busy_ok, 1);
        chk("z_cw", r_cw, 0);
        chk("z_last", r_last_ok, 1);
        chk("z_emit_len", r_ecyc, 64);
        chk("z_err", err, 0);

        // single set bit in the last payload position
        run_frame(40'h1, 0, 0);
        chk("one_cw", r_cw, CW1);
        chk("one_latency", r_lat, 42);
        chk("one_last", r_last_ok, 1);
        chk("one_post_rdy", r_post_rdy, 1);

        // downstream stalls every other cycle
        run_frame(40'h1, 1, 0);
        chk("stall_cw", r_cw, CW1);
        chk("stall_emit_len", r_ecyc, 127);
        chk("stall_stable", r_stab_ok, 1);
        chk("stall_last", r_last_ok, 1);

        // encoder reports a short count
        force_bad = 1;
        run_frame(40'h1, 0, 0);
        force_bad = 0;
        chk("bad_err_at_emit", r_errat, 1);
        chk("bad_cw", r_cw, CW1);
        run_frame('0, 0, 0);
        chk("bad_err_sticky", err, 1);
        chk("bad_next_cw", r_cw, 0);

        // reset in the 20th encode cycle
        in_valid = 1'b1; in_data = 40'h1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_in_encode", enc_shift, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_tx_valid", tx_valid, 0);
        chk("mid_enc_shift", enc_shift, 0);
        chk("mid_enc_rst", enc_rst, 0);
        chk("mid_err", err, 0);
        chk("mid_enc_data", enc_data, 0);
        chk("mid_tx_bit_last", {tx_bit, tx_last}, 0);
        @(negedge clk); rst = 1'b1;
        idle_ok = 1;
        repeat (50) begin
            @(negedge clk);
            if (tx_valid || !in_ready || enc_shift || enc_rst) idle_ok = 0;
        end
        chk("mid_no_partial", idle_ok, 1);
        run_frame(40'h1, 0, 0);
        chk("mid_next_cw", r_cw, CW1);

        // back-to-back with in_valid held high
        run_frame(40'h1, 0, 1);
        chk("b2b_busy1", r_busy_ok, 1);
        chk("b2b_post_rdy", r_post_rdy, 1);
        chk("b2b_post_vld", r_post_vld, 0);
        chk("b2b_cw1", r_cw, CW1);
        run_frame('0, 0, 1);
        chk("b2b_wait", r_wait, 0);
        chk("b2b_busy2", r_busy_ok, 1);
        chk("b2b_cw2", r_cw, 0);
        chk("b2b_latency2", r_lat, 42);
        in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
